// File: rtl/instr_mem_fetch.sv
// Instruction memory with a one-stage fetch pipeline.
// After reset the memory is zero-filled one word per cycle (CLEAR), then
// fetches are served with one cycle of latency (RUN). Fetching a word whose
// opcode equals HALT_OPC stops fetching once that response is consumed
// (HALTED) until resume is pulsed. Program writes are accepted in RUN and HALTED.
// Address decoding assumes ADDR_W <= 31 in word mode and ADDR_W <= 29 in byte mode.
module instr_mem_fetch #(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 8,
    parameter int          BYTE_ADDR = 0,
    parameter logic [5:0]  HALT_OPC  = 6'b111111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_inst,
    output logic              rsp_halt,
    output logic              rsp_err,
    input  logic              resume,
    output logic              init_done,
    output logic              halted
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_CLEAR  = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clear_idx_q, clear_idx_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              data_ok_q, data_ok_d;   // response holds real memory data
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_en;

    logic [ADDR_W-1:0] req_idx;
    logic              req_bad;
    logic              accept;
    logic              halt_flag;
    logic              halt_hs;

    // Address decode: word index and out-of-range / misalignment detection.
    generate
        if (BYTE_ADDR != 0) begin : g_byte_addr
            assign req_idx = req_addr[ADDR_W+1:2];
            assign req_bad = (req_addr[31:ADDR_W+2] != '0) || (req_addr[1:0] != 2'b00);
        end else begin : g_word_addr
            assign req_idx = req_addr[ADDR_W-1:0];
            assign req_bad = (req_addr[31:ADDR_W] != '0);
        end
    endgenerate

    // The read register is not reset (block RAM output); data_ok_q gates it so
    // error responses and the reset state present zero.
    assign halt_flag = data_ok_q && (rd_data_q[DATA_W-1 -: 6] == HALT_OPC);
    assign rsp_inst  = data_ok_q ? rd_data_q : '0;
    assign rsp_halt  = halt_flag;
    assign rsp_err   = err_q;
    assign rsp_valid = rsp_valid_q;
    assign req_ready = (state_q == S_RUN) && (!rsp_valid_q || rsp_ready);
    assign init_done = (state_q != S_CLEAR);
    assign halted    = (state_q == S_HALTED);

    assign accept  = req_valid && req_ready;
    assign halt_hs = rsp_valid_q && rsp_ready && halt_flag;

    // Next-state, response pipeline and memory port control.
    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        rsp_valid_d = rsp_valid_q;
        data_ok_d   = data_ok_q;
        err_d       = err_q;
        mem_we      = 1'b0;
        mem_waddr   = prog_addr;
        mem_wdata   = prog_data;
        rd_en       = 1'b0;
        case (state_q)
            S_CLEAR: begin
                mem_we      = 1'b1;
                mem_waddr   = clear_idx_q;
                mem_wdata   = '0;
                clear_idx_d = clear_idx_q + 1'b1;
                if (&clear_idx_q) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                mem_we = prog_we;
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
                if (halt_hs) begin
                    // A request accepted alongside the halt handshake is dropped.
                    state_d     = S_HALTED;
                    rsp_valid_d = 1'b0;
                end else if (accept) begin
                    rsp_valid_d = 1'b1;
                    rd_en       = 1'b1;
                    data_ok_d   = !req_bad;
                    err_d       = req_bad;
                end
            end
            S_HALTED: begin
                mem_we = prog_we;
                if (resume) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_CLEAR;
            clear_idx_q <= '0;
            rsp_valid_q <= 1'b0;
            data_ok_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
            rsp_valid_q <= rsp_valid_d;
            data_ok_q   <= data_ok_d;
            err_q       <= err_d;
        end
    end

    // Single write port plus registered read port; read-first on a collision.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (rd_en) begin
            rd_data_q <= mem[req_idx];
        end
    end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed testbench for instr_mem_fetch: a word-addressed instance carries
// most of the sequence, a byte-addressed instance covers byte decoding.
module tb_instr_mem_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_inst;
    logic        rsp_halt;
    logic        rsp_err;
    logic        resume;
    logic        init_done;
    logic        halted;

    logic        b_req_valid;
    logic        b_req_ready;
    logic [31:0] b_req_addr;
    logic        b_rsp_valid;
    logic [31:0] b_rsp_inst;
    logic        b_rsp_halt;
    logic        b_rsp_err;
    logic        b_init_done;
    logic        b_halted;

    int checks   = 0;
    int failures = 0;

    logic [31:0] prog_words [7];

    always #5 clk = ~clk;

    instr_mem_fetch dut (
        .clk(clk), .rst(rst),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst),
        .rsp_halt(rsp_halt), .rsp_err(rsp_err),
        .resume(resume), .init_done(init_done), .halted(halted)
    );

    instr_mem_fetch #(.BYTE_ADDR(1)) dut_b (
        .clk(clk), .rst(rst),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .rsp_valid(b_rsp_valid), .rsp_ready(1'b1), .rsp_inst(b_rsp_inst),
        .rsp_halt(b_rsp_halt), .rsp_err(b_rsp_err),
        .resume(1'b0), .init_done(b_init_done), .halted(b_halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-18s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        prog_words[0] = 32'h8C030003;
        prog_words[1] = 32'h8C040004;
        prog_words[2] = 32'h8C050005;
        prog_words[3] = 32'h8C060002;
        prog_words[4] = 32'h00C55000;
        prog_words[5] = 32'h00835801;
        prog_words[6] = 32'hFC000000;

        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1; resume = 1'b0;
        b_req_valid = 1'b0; b_req_addr = '0;

        // Reset state
        repeat (3) tick();
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_inst", rsp_inst, 32'd0);
        check("rst_rsp_flags", {30'd0, rsp_halt, rsp_err}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_init_halt", {30'd0, init_done, halted}, 32'd0);

        // CLEAR lasts 256 cycles
        rst = 1'b0;
        repeat (255) tick();
        check("clear_255", {31'd0, init_done}, 32'd0);
        check("clear_ready_0", {31'd0, req_ready}, 32'd0);
        tick();
        check("clear_256", {31'd0, init_done}, 32'd1);

        // Fetch from cleared memory
        req_valid = 1'b1; req_addr = 32'd37;
        #1 check("idle_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        check("cleared_valid", {31'd0, rsp_valid}, 32'd1);
        check("cleared_inst", rsp_inst, 32'd0);
        check("cleared_err", {31'd0, rsp_err}, 32'd0);
        tick();
        check("hs_valid_clear", {31'd0, rsp_valid}, 32'd0);

        // Program words 0..6 (both instances share the program port)
        for (int i = 0; i < 7; i++) begin
            prog_we = 1'b1; prog_addr = 8'(i); prog_data = prog_words[i];
            tick();
        end
        prog_we = 1'b0;

        // Streaming fetch 0..6, one response per cycle
        for (int i = 0; i < 7; i++) begin
            req_valid = 1'b1; req_addr = 32'(i);
            tick();
            check($sformatf("stream_valid_%0d", i), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("stream_inst_%0d", i), rsp_inst, prog_words[i]);
            check($sformatf("stream_halt_%0d", i), {31'd0, rsp_halt}, (i == 6) ? 32'd1 : 32'd0);
        end
        // Request offered in the halt handshake cycle is discarded
        req_addr = 32'd0;
        #1 check("halt_cyc_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        check("halted", {31'd0, halted}, 32'd1);
        check("halted_ready", {31'd0, req_ready}, 32'd0);
        check("halted_discard", {31'd0, rsp_valid}, 32'd0);
        check("halted_init", {31'd0, init_done}, 32'd1);
        tick();
        check("halted_stays", {31'd0, halted}, 32'd1);

        // Resume, then fetch addr 4
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("resume_halted", {31'd0, halted}, 32'd0);
        check("resume_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_addr = 32'd4;
        tick();
        req_valid = 1'b0;
        check("resume_inst", rsp_inst, 32'h00C55000);
        tick();

        // Backpressure
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'd1;
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp_valid_%0d", c), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("bp_inst_%0d", c), rsp_inst, 32'h8C040004);
            check($sformatf("bp_ready_%0d", c), {31'd0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1 check("bp_release_ready", {31'd0, req_ready}, 32'd1);
        tick();
        check("bp_done_valid", {31'd0, rsp_valid}, 32'd0);

        // Out-of-range fetch
        req_valid = 1'b1; req_addr = 32'h100;
        tick();
        req_valid = 1'b0;
        check("oor_err", {31'd0, rsp_err}, 32'd1);
        check("oor_inst", rsp_inst, 32'd0);
        check("oor_halt", {31'd0, rsp_halt}, 32'd0);
        tick();

        // Byte-addressed instance: misaligned and aligned fetch
        b_req_valid = 1'b1; b_req_addr = 32'h6;
        tick();
        check("byte_mis_err", {31'd0, b_rsp_err}, 32'd1);
        check("byte_mis_inst", b_rsp_inst, 32'd0);
        b_req_addr = 32'h4;
        tick();
        b_req_valid = 1'b0;
        check("byte_ok_err", {31'd0, b_rsp_err}, 32'd0);
        check("byte_ok_inst", b_rsp_inst, 32'h8C040004);
        tick();

        // Read-first collision on index 2
        prog_we = 1'b1; prog_addr = 8'd2; prog_data = 32'h12345678;
        req_valid = 1'b1; req_addr = 32'd2;
        tick();
        prog_we = 1'b0;
        check("rf_old", rsp_inst, 32'h8C050005);
        tick();
        req_valid = 1'b0;
        check("rf_new", rsp_inst, 32'h12345678);
        tick();

        // Reset drops a pending response
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'd0;
        tick();
        req_valid = 1'b0;
        check("pend_valid", {31'd0, rsp_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rsp_ready = 1'b1;
        check("rst_drop_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_drop_init", {31'd0, init_done}, 32'd0);

        // Reset at clear index 100 restarts a full CLEAR
        rst = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (255) tick();
        check("reclear_255", {31'd0, init_done}, 32'd0);
        tick();
        check("reclear_256", {31'd0, init_done}, 32'd1);
        req_valid = 1'b1; req_addr = 32'd4;
        tick();
        req_valid = 1'b0;
        check("reclear_inst", rsp_inst, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
